// File: rtl/alu_iter_sequencer.sv
// Iterative driver for a combinational ALU: feeds the result back into operand n
// for a programmed number of iterations, then presents the result under valid/ready.
module alu_iter_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] m_in,
    input  logic [2:0]       opc_in,
    input  logic             c_in,
    input  logic [CNT_W-1:0] count_in,
    output logic [WIDTH-1:0] alu_n,
    output logic [WIDTH-1:0] alu_m,
    output logic [2:0]       alu_opc,
    output logic             alu_c,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             zer,
    output logic             neg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] m_r, m_d;
    logic [2:0]       opc_r, opc_d;
    logic             c_r, c_d;
    logic [CNT_W-1:0] remaining, remaining_d;
    logic [WIDTH-1:0] result_d;
    logic             zer_d, neg_d;
    logic             busy_d, res_valid_d;

    // ALU operands come straight from the transaction registers
    assign alu_n   = acc;
    assign alu_m   = m_r;
    assign alu_opc = opc_r;
    assign alu_c   = c_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            m_r       <= '0;
            opc_r     <= '0;
            c_r       <= 1'b0;
            remaining <= '0;
            result    <= '0;
            zer       <= 1'b0;
            neg       <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            m_r       <= m_d;
            opc_r     <= opc_d;
            c_r       <= c_d;
            remaining <= remaining_d;
            result    <= result_d;
            zer       <= zer_d;
            neg       <= neg_d;
            busy      <= busy_d;
            res_valid <= res_valid_d;
        end
    end

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        m_d         = m_r;
        opc_d       = opc_r;
        c_d         = c_r;
        remaining_d = remaining;
        result_d    = result;
        zer_d       = zer;
        neg_d       = neg;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_d       = n_in;
                    m_d         = m_in;
                    opc_d       = opc_in;
                    c_d         = c_in;
                    remaining_d = count_in;
                    if (count_in != '0) begin
                        state_d = EXEC;
                    end else begin
                        // zero iterations: result is the operand itself, flags made here
                        state_d  = DONE;
                        result_d = n_in;
                        zer_d    = (n_in == '0);
                        neg_d    = n_in[WIDTH-1];
                    end
                end
            end
            EXEC: begin
                acc_d       = alu_f;
                remaining_d = remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state_d  = DONE;
                    result_d = alu_f;
                    zer_d    = alu_zer;
                    neg_d    = alu_neg;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_alu_iter_sequencer.sv
// Directed bench for alu_iter_sequencer with an adder ALU stub and an expected-result queue.
module tb_alu_iter_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] n_in, m_in;
    logic [2:0]       opc_in;
    logic             c_in;
    logic [CNT_W-1:0] count_in;
    logic [WIDTH-1:0] alu_n, alu_m, alu_f;
    logic [2:0]       alu_opc;
    logic             alu_c, alu_zer, alu_neg;
    logic             busy, res_valid, res_ready;
    logic [WIDTH-1:0] result;
    logic             zer, neg;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             n;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // ALU stub: f = n + m + c for every opcode
    assign alu_f   = alu_n + alu_m + WIDTH'(alu_c);
    assign alu_zer = (alu_f == '0);
    assign alu_neg = alu_f[WIDTH-1];

    alu_iter_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .m_in(m_in),
        .opc_in(opc_in), .c_in(c_in), .count_in(count_in),
        .alu_n(alu_n), .alu_m(alu_m), .alu_opc(alu_opc), .alu_c(alu_c),
        .alu_f(alu_f), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .zer(zer), .neg(neg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m,
                                   input logic c, input int cnt);
        logic [WIDTH-1:0] a;
        exp_t e;
        a = n;
        for (int i = 0; i < cnt; i++) a = a + m + WIDTH'(c);
        e.r = a;
        e.z = (a == '0);
        e.n = a[WIDTH-1];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one accepted request and record its expected outcome
    task automatic accept(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m,
                          input logic c, input logic [2:0] opc, input int cnt);
        n_in = n; m_in = m; c_in = c; opc_in = opc; count_in = CNT_W'(cnt);
        start = 1'b1;
        step();
        start = 1'b0;
        sb.push_back(model(n, m, c, cnt));
        check("busy_after_accept", 32'(busy), 32'd1);
        check("alu_m_reg", 32'(alu_m), 32'(m));
        check("alu_opc_reg", 32'(alu_opc), 32'(opc));
        check("alu_c_reg", 32'(alu_c), 32'(c));
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        while (!res_valid && lat < 40) begin
            step();
            lat++;
        end
        check(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.r));
            check({tag, "_zer"}, 32'(zer), 32'(e.z));
            check({tag, "_neg"}, 32'(neg), 32'(e.n));
        end
    endtask

    // complete handshake (res_ready already high) and confirm one-cycle valid
    task automatic finish_hs(input string tag);
        step();
        check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        n_in = '0; m_in = '0; opc_in = '0; c_in = 1'b0; count_in = '0;
        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(res_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_alu_n", 32'(alu_n), 32'd0);
        rst = 1'b0;
        step();

        // basic: 8 + 3*3 = 17
        accept(16'd8, 16'd3, 1'b0, 3'd2, 3);
        wait_valid("basic_latency", 3);
        pop_check("basic");
        finish_hs("basic");

        // carry-in and negative: -10 + 2*(2+1) = -4
        step();
        accept(16'hFFF6, 16'd2, 1'b1, 3'd5, 2);
        wait_valid("carry_latency", 2);
        pop_check("carry");
        check("carry_value", 32'(result), 32'h0000FFFC);
        finish_hs("carry");

        // wrap to zero
        step();
        accept(16'hFFFE, 16'd1, 1'b0, 3'd0, 2);
        wait_valid("wrap0_latency", 2);
        pop_check("wrap0");
        finish_hs("wrap0");

        // signed overflow into negative
        step();
        accept(16'h7FFF, 16'd1, 1'b0, 3'd1, 1);
        wait_valid("ovf_latency", 1);
        pop_check("ovf");
        finish_hs("ovf");

        // result persists after handshake
        check("result_persist", 32'(result), 32'h00008000);

        // count=0 bypass: no ALU iteration, acc holds n_in while ALU output differs
        step();
        res_ready = 1'b0;
        accept(16'd0, 16'd5, 1'b0, 3'd3, 0);
        wait_valid("bypass_latency", 0);
        pop_check("bypass");
        for (int i = 0; i < 3; i++) begin
            check("bypass_alu_n", 32'(alu_n), 32'd0);
            step();
        end
        res_ready = 1'b1;
        finish_hs("bypass");

        // handshake hold and ignored starts during EXEC and DONE
        step();
        res_ready = 1'b0;
        accept(16'd1, 16'd1, 1'b0, 3'd4, 2);
        n_in = 16'd100; m_in = 16'd50; count_in = CNT_W'(1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("hold_latency", 1);
        pop_check("hold");
        for (int i = 0; i < 5; i++) begin
            n_in = 16'(200 + i); start = 1'b1;
            step();
            check("hold_result", 32'(result), 32'd3);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_valid", 32'(res_valid), 32'd1);
        end
        start = 1'b0;
        res_ready = 1'b1;
        finish_hs("hold");
        check("no_queued_start", 32'(busy), 32'd0);

        // next request accepted with fresh operands: 100 + 50*1 = 150
        accept(16'd100, 16'd50, 1'b0, 3'd6, 1);
        wait_valid("next_latency", 1);
        pop_check("next");
        finish_hs("next");

        // reset mid-EXEC discards the transaction
        step();
        n_in = 16'd7; m_in = 16'd1; c_in = 1'b0; count_in = CNT_W'(10);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(res_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_zer", 32'(zer), 32'd0);
        check("midrst_neg", 32'(neg), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                step();
                if (res_valid) seen++;
            end
            check("midrst_no_valid", 32'(seen), 32'd0);
        end
        check("queue_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
